// File: rtl/mp_mem_pkg.sv
// ---------------------------------------------------------------------------
// mp_mem_pkg
// Shared constants and types for the two-core lpmRAM arbiter.
//   DATA_W  : RAM word width
//   ADDR_W  : requester (virtual) word address width
//   PADDR_W : RAM physical address width
//   WIN     : words per requester window (requester k owns [k*WIN, k*WIN+WIN-1])
// Types:
//   req_id_t     : 1-bit requester index
//   lock_state_t : lock FSM states (used only when ARB_LOCK_EN is defined)
// Helpers:
//   in_window()  : virtual address falls inside the requester's window
//   phys_addr()  : virtual -> physical translation for requester k
// ---------------------------------------------------------------------------
package mp_mem_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int PADDR_W = 6;
    localparam int WIN     = 32;
    localparam int WIN_LG  = $clog2(WIN);

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(WIN);
    endfunction

    // Window base is k*WIN; only the low WIN_LG bits of the virtual address
    // select a word inside the window.
    function automatic logic [PADDR_W-1:0] phys_addr(input req_id_t k,
                                                     input logic [ADDR_W-1:0] a);
        logic [PADDR_W-1:0] base;
        base = k ? PADDR_W'(WIN) : '0;
        return base + PADDR_W'(a[WIN_LG-1:0]);
    endfunction

endpackage

// File: rtl/ram_arbiter2_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant with a last-winner register.
//   clock   : system clock
//   resetN  : asynchronous active-low reset (grants forced low while asserted)
//   req0/1  : eligible requests
//   gnt0/1  : combinational one-hot (or zero) grant
// On contention the requester that did not win last time is granted. The
// last winner resets to 1 so requester 0 wins the first contention.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic clock,
    input  logic resetN,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic last_gnt_reg;

    always_comb begin
        gnt0 = resetN & req0 & (~req1 | last_gnt_reg);
        gnt1 = resetN & req1 & (~req0 | ~last_gnt_reg);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            last_gnt_reg <= 1'b1;
        end else if (gnt0) begin
            last_gnt_reg <= 1'b0;
        end else if (gnt1) begin
            last_gnt_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter2.sv
// ---------------------------------------------------------------------------
// ram_arbiter2
// Shares one single-port lpmRAM (registered address, q one cycle later)
// between two cores. Each core sees a private WIN-word window.
//
// Ports:
//   clock, resetN               : clock, asynchronous active-low reset
//   reqK, weK, addrK, wdataK    : requester K access (held until gntK)
//   lockK (ARB_LOCK_EN only)    : keep the RAM locked to K after this grant
//   gntK                        : combinational, access accepted this cycle
//   rvalidK, faultK             : registered one-cycle response pulses
//   rdata                       : shared read-return bus
//   ram_addr, ram_din, ram_w    : to lpmRAM
//   ram_q                       : from lpmRAM
//
// Optional feature: define ARB_LOCK_EN to add lock0/lock1 and the lock FSM
// (UNLOCKED / LOCKED0 / LOCKED1) used for atomic read-modify-write.
// ---------------------------------------------------------------------------
module ram_arbiter2
    import mp_mem_pkg::*;
(
    input  logic               clock,
    input  logic               resetN,
    input  logic               req0,
    input  logic               we0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [DATA_W-1:0]  wdata0,
    output logic               gnt0,
    output logic               rvalid0,
    output logic               fault0,
    input  logic               req1,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  wdata1,
    output logic               gnt1,
    output logic               rvalid1,
    output logic               fault1,
`ifdef ARB_LOCK_EN
    input  logic               lock0,
    input  logic               lock1,
`endif
    output logic [DATA_W-1:0]  rdata,
    output logic [PADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]  ram_din,
    output logic               ram_w,
    input  logic [DATA_W-1:0]  ram_q
);

    logic               elig0;
    logic               elig1;
    logic               any_gnt;
    req_id_t            sel;

    logic               we_a     [2];
    logic [ADDR_W-1:0]  addr_a   [2];
    logic [DATA_W-1:0]  wdata_a  [2];
    logic               gnt_a    [2];
    logic               inwin_a  [2];
    logic [PADDR_W-1:0] paddr_a  [2];
    logic               rvalid_reg [2];
    logic               fault_reg  [2];

    logic [PADDR_W-1:0] ram_addr_hold_reg;
    logic [DATA_W-1:0]  ram_din_hold_reg;
    logic [DATA_W-1:0]  rdata_hold_reg;
    logic               rsp_any;
    logic               rsp_fault;

    assign we_a[0]    = we0;
    assign we_a[1]    = we1;
    assign addr_a[0]  = addr0;
    assign addr_a[1]  = addr1;
    assign wdata_a[0] = wdata0;
    assign wdata_a[1] = wdata1;
    assign gnt_a[0]   = gnt0;
    assign gnt_a[1]   = gnt1;

    // -----------------------------------------------------------------------
    // Lock FSM: while locked to one requester the other is made ineligible.
    // -----------------------------------------------------------------------
`ifdef ARB_LOCK_EN
    lock_state_t lock_state_reg;

    assign elig0 = req0 & (lock_state_reg != LOCKED1);
    assign elig1 = req1 & (lock_state_reg != LOCKED0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lock_state_reg <= UNLOCKED;
        end else begin
            case (lock_state_reg)
                UNLOCKED, LOCKED0, LOCKED1: begin
                    if (gnt0) begin
                        lock_state_reg <= lock0 ? LOCKED0 : UNLOCKED;
                    end else if (gnt1) begin
                        lock_state_reg <= lock1 ? LOCKED1 : UNLOCKED;
                    end
                end
                default: lock_state_reg <= UNLOCKED;
            endcase
        end
    end
`else
    assign elig0 = req0;
    assign elig1 = req1;
`endif

    rr_arb2 u_arb (
        .clock  (clock),
        .resetN (resetN),
        .req0   (elig0),
        .req1   (elig1),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign any_gnt = gnt0 | gnt1;
    assign sel     = gnt1;

    // -----------------------------------------------------------------------
    // Per-requester translation and response pipeline. A response pulse is
    // generated for reads and for any out-of-window access; in-window writes
    // complete silently.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign inwin_a[gi] = in_window(addr_a[gi]);
            assign paddr_a[gi] = phys_addr(req_id_t'(gi), addr_a[gi]);

            always_ff @(posedge clock or negedge resetN) begin
                if (!resetN) begin
                    rvalid_reg[gi] <= 1'b0;
                    fault_reg[gi]  <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= gnt_a[gi] & (~we_a[gi] | ~inwin_a[gi]);
                    fault_reg[gi]  <= gnt_a[gi] & ~inwin_a[gi];
                end
            end
        end
    endgenerate

    // RAM side: drive the granted requester's translated access; on idle
    // cycles keep the last address/data on the bus.
    always_comb begin
        ram_addr = ram_addr_hold_reg;
        ram_din  = ram_din_hold_reg;
        ram_w    = 1'b0;
        if (any_gnt) begin
            ram_addr = paddr_a[sel];
            ram_din  = wdata_a[sel];
            ram_w    = we_a[sel] & inwin_a[sel];
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ram_addr_hold_reg <= '0;
            ram_din_hold_reg  <= '0;
        end else if (any_gnt) begin
            ram_addr_hold_reg <= ram_addr;
            ram_din_hold_reg  <= ram_din;
        end
    end

    // Read return: ram_q is valid in the cycle after the grant, which is the
    // same cycle the response pulse is high. Faults return zero.
    assign rsp_any   = rvalid_reg[0] | rvalid_reg[1];
    assign rsp_fault = (rvalid_reg[0] & fault_reg[0]) | (rvalid_reg[1] & fault_reg[1]);

    always_comb begin
        rdata = rdata_hold_reg;
        if (rsp_any) begin
            rdata = rsp_fault ? '0 : ram_q;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rdata_hold_reg <= '0;
        end else if (rsp_any) begin
            rdata_hold_reg <= rdata;
        end
    end

    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign fault0  = fault_reg[0];
    assign fault1  = fault_reg[1];

endmodule

// File: doc/ram_arbiter2.md
Name: ram_arbiter2

Overview:
- Shares the single-port lpmRAM (64 x 16, registered address, read data one cycle after address) between two processor cores.
- Each core owns a private 32-word physical window.
- Per cycle: round-robin arbitration, address translation, one committed RAM access per clock, read-return pipelining.
- Sits between the cores' addr/din/w buses and lpmRAM, in place of the per-core TLB path.

Parameters:
- DATA_W, 16, RAM word width
- ADDR_W, 16, requester (virtual) address width
- PADDR_W, 6, RAM physical address width
- WIN, 32, words per requester window; requester k maps to physical [k*WIN, k*WIN+WIN-1]; WIN*2 <= 2**PADDR_W

Ports:
- clock  in  1  system clock, all state on posedge
- resetN  in  1  asynchronous active-low reset
- req0  in  1  requester 0 access request; held with we0/addr0/wdata0 stable until gnt0
- we0  in  1  1 = write, 0 = read
- addr0  in  ADDR_W  requester 0 virtual word address
- wdata0  in  DATA_W  write data
- gnt0  out  1  combinational; access accepted this cycle
- rvalid0  out  1  registered; read data/fault response for requester 0
- fault0  out  1  registered; out-of-window access, pulses with rvalid0
- req1, we1, addr1, wdata1, gnt1, rvalid1, fault1: same for requester 1
- rdata  out  DATA_W  shared read-return bus, qualified by rvalid0/rvalid1
- ram_addr  out  PADDR_W  to lpmRAM address
- ram_din  out  DATA_W  to lpmRAM data
- ram_w  out  1  to lpmRAM write enable
- ram_q  in  DATA_W  from lpmRAM q

Behaviour:
- Reset (resetN=0, async): rvalid0/1=0, fault0/1=0, rdata=0, last_gnt=1 (requester 0 wins first contention). gnt0/1=0 and ram_w=0 while resetN=0.
- Arbitration (combinational):
  - Only one requester active: it is granted.
  - Both active: grant the one not equal to last_gnt.
  - At most one gnt per cycle.
  - last_gnt updates on every posedge with a grant.
- Starvation bound: a held request waits at most 1 cycle.
- Translation for the granted requester k:
  - in-window if addr_k < WIN
  - ram_addr = k*WIN + addr_k[log2(WIN)-1:0]
  - ram_din = wdata_k
  - ram_w = we_k & in-window
- Idle cycle (no grant): ram_w=0; ram_addr and ram_din hold their previous values.
- Write: committed at the posedge ending the gnt cycle. No rvalid. Zero response latency.
- Read: rvalid_k=1 exactly one cycle after gnt_k, with rdata=ram_q.
  - Latency 1.
  - Back-to-back grants every cycle are allowed; responses return in grant order.
- Fault (addr_k >= WIN, read or write):
  - Grant still issued (request consumed), no RAM write.
  - Next cycle: rvalid_k=1, fault_k=1, rdata=0.
  - For a faulting write, rvalid_k pulses only to carry fault_k.
- rvalid/fault are single-cycle pulses. rdata holds its last value when no rvalid is asserted.
- Simultaneous events:
  - A read response for one requester and a grant to the other in the same cycle are independent and both proceed.
  - Same-address write by one requester and read by the other cannot occur, because windows are disjoint.
- Reset mid-operation: a read granted in the cycle reset asserts produces no rvalid after reset releases.
- Requester dropping req before gnt: legal, nothing happens.

Optional Feature:
- Macro ARB_LOCK_EN.
- With the macro:
  - Adds ports lock0, lock1 (in, 1).
  - Lock FSM states UNLOCKED, LOCKED0, LOCKED1.
  - A grant to k with lock_k=1 moves the FSM to LOCKEDk. In LOCKEDk only requester k can be granted.
  - A grant to k with lock_k=0 returns the FSM to UNLOCKED.
  - Reset goes to UNLOCKED.
  - Purpose: atomic read-modify-write.
- Without the macro: no lock ports; pure round-robin as above.

Decomposition:
- Package mp_mem_pkg: DATA_W/ADDR_W/PADDR_W/WIN constants, 1-bit req_id type, lock_state enum (UNLOCKED, LOCKED0, LOCKED1).
- One sub-module rr_arb2: combinational 2-way round-robin grant plus last_gnt register.
- Translation, response pipeline and lock FSM live in ram_arbiter2.

Test Plan:
- Reset: hold resetN=0 with req0=req1=1 -> gnt0=gnt1=0, ram_w=0, rvalid=0. Release -> the first contention grants requester 0.
- Write/read: req0 we0=1 addr0=5 wdata0=16'hBEEF. Then req1 we1=0 addr1=5 -> physical 5 written; requester 1 reads physical 37, rvalid1 next cycle with rdata = RAM[37], not 16'hBEEF.
- Contention: req0 and req1 held for 4 cycles -> grants alternate 0,1,0,1; each read response arrives in the following cycle to the matching rvalid.
- Fault: req1 we1=1 addr1=40 -> gnt1=1, ram_w=0. Next cycle rvalid1=1, fault1=1, rdata=0; RAM[8] and RAM[40] unchanged.
- Mid-read reset: grant read to requester 0, assert resetN=0 the same cycle -> rvalid0 stays 0 and outputs return to reset values.
- ARB_LOCK_EN: req0 with lock0=1 at addr 3, req1 pending -> requester 1 is blocked until requester 0 issues a grant with lock0=0, then gnt1 in the next cycle.
